cpu_div_issue: RTL and testbench

Pipeline-side controller for the iterative divider: accepts DIVU/DIVS/MODU/MODS from stage p3, converts operands to magnitude plus result sign, and launches the divider. It tracks the latent destination register in a one-entry scoreboard and stalls dependent instructions. It captures the one-cycle divider result and merges it into the register-file write port, holding it if the main pipeline owns that port.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/cpu_div_hazard.sv | 37 +++
 rtl/cpu_div_issue.sv | 165 ++++++++++++++++
 tb/tb_cpu_div_issue.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the divide issue path: FSM states, op-field encodings, helpers.
// Latency: none, declarations only.
// Backpressure: not applicable.
package cpu_pkg;

  // Divide controller states.
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_HOLD = 2'd2
  } div_state_e;

  // Op-field encodings carried from p3.
  localparam logic OP_SIGNED = 1'b1;  // DIVS / MODS
  localparam logic OP_MOD    = 1'b1;  // MODU / MODS return the remainder

  // 32-bit two's-complement magnitude; 0x80000000 maps to itself.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/cpu_div_hazard.sv
// Compares the p2 register fields against the pending and the issuing divide destination.
// Latency: purely combinational.
// Backpressure: none here; the results feed the pipeline stall.
module cpu_div_hazard (
  input  logic [4:0] i_p2_src_a,
  input  logic [4:0] i_p2_src_b,
  input  logic [4:0] i_p2_dest,
  input  logic       i_p2_use_a,
  input  logic       i_p2_use_b,
  input  logic       i_p2_write,
  input  logic       i_pend_valid,
  input  logic [4:0] i_pend_dest,
  input  logic       i_issue_valid,
  input  logic [4:0] i_issue_dest,
  output logic       o_hazard_pend,
  output logic       o_hazard_issue
);

  // A field hits when it is in use, is not r0, and names the destination.
  function automatic logic hit(input logic use_f, input logic [4:0] f, input logic [4:0] d);
    return use_f && (f != 5'd0) && (f == d);
  endfunction

  logic w_any_pend;
  logic w_any_issue;

  assign w_any_pend  = hit(i_p2_use_a, i_p2_src_a, i_pend_dest)
                     | hit(i_p2_use_b, i_p2_src_b, i_pend_dest)
                     | hit(i_p2_write, i_p2_dest,  i_pend_dest);
  assign w_any_issue = hit(i_p2_use_a, i_p2_src_a, i_issue_dest)
                     | hit(i_p2_use_b, i_p2_src_b, i_issue_dest)
                     | hit(i_p2_write, i_p2_dest,  i_issue_dest);

  assign o_hazard_pend  = i_pend_valid  & w_any_pend;
  assign o_hazard_issue = i_issue_valid & w_any_issue;

endmodule

// File: rtl/cpu_div_issue.sv
// Issues divide-class ops from p3 to the iterative divider and merges its result into writeback.
// Latency: launch is combinational in the accept cycle; writeback 0 cycles after div_valid, 1 if held.
// Backpressure: stall freezes p2/p3/p4 on dependency, busy/not-ready divider, or a held writeback.
module cpu_div_issue
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        p3_div_op,
  input  logic        p3_div_signed,
  input  logic        p3_div_mod,
  input  logic [31:0] p3_src_a,
  input  logic [31:0] p3_src_b,
  input  logic [4:0]  p3_dest,
  input  logic [4:0]  p2_src_a,
  input  logic [4:0]  p2_src_b,
  input  logic [4:0]  p2_dest,
  input  logic        p2_use_a,
  input  logic        p2_use_b,
  input  logic        p2_write,
  input  logic        p4_wb_en,
  output logic        stall,
  output logic        div_start,
  output logic [31:0] div_numerator,
  output logic [31:0] div_denominator,
  output logic [4:0]  div_latent_dest,
  output logic        div_sign,
  output logic        div_mod,
  input  logic        div_ready,
  input  logic        div_valid,
  input  logic [31:0] div_result,
  input  logic [4:0]  div_dest_reg,
  output logic        wbd_en,
  output logic [4:0]  wbd_reg,
  output logic [31:0] wbd_data
);

  div_state_e  r_state;
  div_state_e  w_state_nxt;
  logic        r_pend_valid;
  logic [4:0]  r_pend_dest;
  logic [4:0]  r_hold_reg;
  logic [31:0] r_hold_data;

  logic        w_is_signed;
  logic        w_is_mod;
  logic        w_sign;
  logic        w_start;
  logic        w_hazard_pend;
  logic        w_hazard_issue;
  logic        w_hazard;
  logic        w_wb_en;
  logic [4:0]  w_wb_reg;
  logic [31:0] w_wb_data;
  logic        w_hold_load;

  assign w_is_signed = (p3_div_signed == OP_SIGNED);
  assign w_is_mod    = (p3_div_mod == OP_MOD);

  // Remainder takes the numerator's sign; quotient is negative when the signs differ.
  assign w_sign = w_is_signed & (w_is_mod ? p3_src_a[31] : (p3_src_a[31] ^ p3_src_b[31]));

  // pend_valid is always clear in IDLE, so the pending term never blocks a launch in practice;
  // the issue-dest hazard stalls p2 alongside the launch and does not gate it.
  assign w_start = ~reset & p3_div_op & div_ready & (r_state == DIV_IDLE) & ~w_hazard_pend;

  cpu_div_hazard u_hazard (
    .i_p2_src_a     (p2_src_a),
    .i_p2_src_b     (p2_src_b),
    .i_p2_dest      (p2_dest),
    .i_p2_use_a     (p2_use_a),
    .i_p2_use_b     (p2_use_b),
    .i_p2_write     (p2_write),
    .i_pend_valid   (r_pend_valid),
    .i_pend_dest    (r_pend_dest),
    .i_issue_valid  (w_start),
    .i_issue_dest   (p3_dest),
    .o_hazard_pend  (w_hazard_pend),
    .o_hazard_issue (w_hazard_issue)
  );

  assign w_hazard = w_hazard_pend | w_hazard_issue;

  assign stall = ~reset & (w_hazard
                         | (p3_div_op & (r_state != DIV_IDLE))
                         | (p3_div_op & ~div_ready)
                         | (r_state == DIV_HOLD));

  // Operand outputs are driven only in the launch cycle and read as zero otherwise.
  assign div_start       = w_start;
  assign div_numerator   = w_start ? (w_is_signed ? abs32(p3_src_a) : p3_src_a) : 32'd0;
  assign div_denominator = w_start ? (w_is_signed ? abs32(p3_src_b) : p3_src_b) : 32'd0;
  assign div_latent_dest = w_start ? p3_dest : 5'd0;
  assign div_sign        = w_start & w_sign;
  assign div_mod         = w_start & w_is_mod;

  assign wbd_en   = ~reset & w_wb_en;
  assign wbd_reg  = wbd_en ? w_wb_reg  : 5'd0;
  assign wbd_data = wbd_en ? w_wb_data : 32'd0;

  // Next-state and writeback selection; r0 results still move the FSM but never write.
  always_comb begin
    w_state_nxt = r_state;
    w_wb_en     = 1'b0;
    w_wb_reg    = 5'd0;
    w_wb_data   = 32'd0;
    w_hold_load = 1'b0;
    case (r_state)
      DIV_IDLE: begin
        if (w_start) w_state_nxt = DIV_BUSY;
      end
      DIV_BUSY: begin
        if (div_valid) begin
          if (!p4_wb_en) begin
            w_wb_en     = (div_dest_reg != 5'd0);
            w_wb_reg    = div_dest_reg;
            w_wb_data   = div_result;
            w_state_nxt = DIV_IDLE;
          end else begin
            w_hold_load = 1'b1;
            w_state_nxt = DIV_HOLD;
          end
        end
      end
      DIV_HOLD: begin
        w_wb_en     = (r_hold_reg != 5'd0);
        w_wb_reg    = r_hold_reg;
        w_wb_data   = r_hold_data;
        w_state_nxt = DIV_IDLE;
      end
      default: w_state_nxt = DIV_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= DIV_IDLE;
    else       r_state <= w_state_nxt;
  end

  // One-entry scoreboard: set on launch to a real register, cleared when that register is written.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pend_valid <= 1'b0;
      r_pend_dest  <= 5'd0;
    end else if (w_start && (p3_dest != 5'd0)) begin
      r_pend_valid <= 1'b1;
      r_pend_dest  <= p3_dest;
    end else if (w_wb_en && (w_wb_reg == r_pend_dest)) begin
      r_pend_valid <= 1'b0;
    end
  end

  // Capture the one-cycle divider result when p4 owns the write port.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hold_reg  <= 5'd0;
      r_hold_data <= 32'd0;
    end else if (w_hold_load) begin
      r_hold_reg  <= div_dest_reg;
      r_hold_data <= div_result;
    end
  end

endmodule

// File: tb/tb_cpu_div_issue.sv
// Self-checking bench for cpu_div_issue with a behavioural 33-cycle divider and a writeback scoreboard.
// Latency: divider returns div_valid 33 cycles after div_start.
// Backpressure: exercised through hazards, busy divider and writeback-port collisions.
module tb_cpu_div_issue;

  logic        clock, reset;
  logic        p3_div_op, p3_div_signed, p3_div_mod;
  logic [31:0] p3_src_a, p3_src_b;
  logic [4:0]  p3_dest;
  logic [4:0]  p2_src_a, p2_src_b, p2_dest;
  logic        p2_use_a, p2_use_b, p2_write;
  logic        p4_wb_en;
  logic        stall, div_start;
  logic [31:0] div_numerator, div_denominator;
  logic [4:0]  div_latent_dest;
  logic        div_sign, div_mod;
  logic        div_ready, div_valid;
  logic [31:0] div_result;
  logic [4:0]  div_dest_reg;
  logic        wbd_en;
  logic [4:0]  wbd_reg;
  logic [31:0] wbd_data;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } sb_t;

  typedef struct {
    logic        sg;
    logic        md;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  d;
    logic [31:0] e_num;
    logic [31:0] e_den;
    logic        e_sign;
    logic [31:0] e_res;
  } vec_t;

  localparam int NV = 10;
  vec_t vt [NV];

  sb_t sb_q[$];
  sb_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  wb_count = 0;

  // divider model state
  logic        m_pending, m_busy;
  logic [31:0] m_num, m_den;
  logic        m_sign, m_mod;
  logic [4:0]  m_dest;
  int          m_cnt;

  cpu_div_issue dut (
    .clock(clock), .reset(reset),
    .p3_div_op(p3_div_op), .p3_div_signed(p3_div_signed), .p3_div_mod(p3_div_mod),
    .p3_src_a(p3_src_a), .p3_src_b(p3_src_b), .p3_dest(p3_dest),
    .p2_src_a(p2_src_a), .p2_src_b(p2_src_b), .p2_dest(p2_dest),
    .p2_use_a(p2_use_a), .p2_use_b(p2_use_b), .p2_write(p2_write),
    .p4_wb_en(p4_wb_en), .stall(stall), .div_start(div_start),
    .div_numerator(div_numerator), .div_denominator(div_denominator),
    .div_latent_dest(div_latent_dest), .div_sign(div_sign), .div_mod(div_mod),
    .div_ready(div_ready), .div_valid(div_valid), .div_result(div_result),
    .div_dest_reg(div_dest_reg), .wbd_en(wbd_en), .wbd_reg(wbd_reg), .wbd_data(wbd_data)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=still running required=finished");
    $fatal(1);
  end

  function automatic logic [31:0] mdl_result(input logic [31:0] n, input logic [31:0] dn,
                                             input logic md, input logic sg);
    logic [31:0] q, r, v;
    q = (dn == 32'd0) ? 32'hFFFF_FFFF : n / dn;
    r = (dn == 32'd0) ? n : n % dn;
    v = md ? r : q;
    return sg ? (~v + 32'd1) : v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // divider: latch the launch between edges, away from the active edge
  always begin
    @(negedge clock);
    #3;
    if (!reset && div_start) begin
      m_pending = 1'b1;
      m_num  = div_numerator;
      m_den  = div_denominator;
      m_sign = div_sign;
      m_mod  = div_mod;
      m_dest = div_latent_dest;
    end
  end

  // divider: advance just after each active edge
  always begin
    @(posedge clock);
    #1;
    if (reset) begin
      m_busy = 1'b0; m_pending = 1'b0; m_cnt = 0;
      div_valid = 1'b0; div_ready = 1'b1; div_result = 32'd0; div_dest_reg = 5'd0;
    end else begin
      if (div_valid) begin
        div_valid = 1'b0; div_result = 32'd0; m_busy = 1'b0; div_ready = 1'b1;
      end
      if (m_pending) begin
        m_pending = 1'b0; m_busy = 1'b1; div_ready = 1'b0; m_cnt = 1;
      end else if (m_busy) begin
        m_cnt++;
        if (m_cnt == 33) begin
          div_valid    = 1'b1;
          div_dest_reg = m_dest;
          div_result   = mdl_result(m_num, m_den, m_mod, m_sign);
        end
      end
    end
  end

  // writeback monitor against the scoreboard
  always begin
    @(negedge clock);
    #2;
    if (!reset && wbd_en) begin
      wb_count++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected actual=r%0d:%h required=no write", wbd_reg, wbd_data);
      end else begin
        mon_e = sb_q.pop_front();
        if (wbd_reg !== mon_e.rd || wbd_data !== mon_e.data) begin
          errors++;
          $display("FAIL wb_result actual=r%0d:%h required=r%0d:%h", wbd_reg, wbd_data, mon_e.rd, mon_e.data);
        end
      end
    end
  end

  task automatic drive_op(input logic sg, input logic md, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] d);
    p3_div_op = 1'b1; p3_div_signed = sg; p3_div_mod = md;
    p3_src_a = a; p3_src_b = b; p3_dest = d;
  endtask

  // returns at negedge+1 of the launch cycle
  task automatic wait_start(input string nm, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      #1;
      if (div_start) ok = 1'b1;
      else @(negedge clock);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s_start_timeout actual=no div_start required=div_start", nm);
    end
  endtask

  task automatic wait_drain(input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (sb_q.size() == 0 && !m_busy && !div_valid) done = 1'b1;
      else @(negedge clock);
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_drain_timeout actual=%0d pending required=0", nm, sb_q.size());
    end
  endtask

  initial begin
    bit ok, seen;
    int wb0, low, early;

    reset = 1'b1;
    p3_div_op = 0; p3_div_signed = 0; p3_div_mod = 0; p3_src_a = 0; p3_src_b = 0; p3_dest = 0;
    p2_src_a = 0; p2_src_b = 0; p2_dest = 0; p2_use_a = 0; p2_use_b = 0; p2_write = 0;
    p4_wb_en = 0;
    div_ready = 1'b1; div_valid = 1'b0; div_result = 0; div_dest_reg = 0;
    m_pending = 0; m_busy = 0; m_cnt = 0;

    vt[0] = '{sg:0, md:0, a:32'd100,        b:32'd7,          d:5'd5,  e_num:32'd100,        e_den:32'd7, e_sign:0, e_res:32'd14};
    vt[1] = '{sg:1, md:0, a:32'hFFFF_FFF9,  b:32'd2,          d:5'd6,  e_num:32'd7,          e_den:32'd2, e_sign:1, e_res:32'hFFFF_FFFD};
    vt[2] = '{sg:1, md:1, a:32'hFFFF_FFF9,  b:32'd2,          d:5'd7,  e_num:32'd7,          e_den:32'd2, e_sign:1, e_res:32'hFFFF_FFFF};
    vt[3] = '{sg:1, md:1, a:32'd7,          b:32'hFFFF_FFFE,  d:5'd8,  e_num:32'd7,          e_den:32'd2, e_sign:0, e_res:32'd1};
    vt[4] = '{sg:0, md:0, a:32'd9,          b:32'd0,          d:5'd9,  e_num:32'd9,          e_den:32'd0, e_sign:0, e_res:32'hFFFF_FFFF};
    vt[5] = '{sg:1, md:0, a:32'h8000_0000,  b:32'd2,          d:5'd10, e_num:32'h8000_0000,  e_den:32'd2, e_sign:1, e_res:32'hC000_0000};
    vt[6] = '{sg:0, md:1, a:32'd100,        b:32'd7,          d:5'd11, e_num:32'd100,        e_den:32'd7, e_sign:0, e_res:32'd2};
    vt[7] = '{sg:1, md:0, a:32'hFFFF_FF9C,  b:32'hFFFF_FFF9,  d:5'd12, e_num:32'd100,        e_den:32'd7, e_sign:0, e_res:32'd14};
    vt[8] = '{sg:0, md:0, a:32'd5,          b:32'd1,          d:5'd0,  e_num:32'd5,          e_den:32'd1, e_sign:0, e_res:32'd5};
    vt[9] = '{sg:0, md:0, a:32'hFFFF_FFF9,  b:32'd2,          d:5'd18, e_num:32'hFFFF_FFF9,  e_den:32'd2, e_sign:0, e_res:32'h7FFF_FFFC};

    // reset state, with a divide op presented while reset is held
    repeat (2) @(negedge clock);
    drive_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd7, 5'd5);
    #1;
    check("rst_stall",     {31'd0, stall},     32'd0);
    check("rst_div_start", {31'd0, div_start}, 32'd0);
    check("rst_wbd_en",    {31'd0, wbd_en},    32'd0);
    check("rst_div_sign",  {31'd0, div_sign},  32'd0);
    check("rst_div_mod",   {31'd0, div_mod},   32'd0);
    check("rst_num",       div_numerator,      32'd0);
    check("rst_wbd_data",  wbd_data,           32'd0);
    @(negedge clock);
    p3_div_op = 1'b0; reset = 1'b0;
    #1;
    check("idle_stall", {31'd0, stall}, 32'd0);

    // table-driven operand / sign / result vectors
    for (int i = 0; i < NV; i++) begin
      @(negedge clock);
      wb0 = wb_count;
      drive_op(vt[i].sg, vt[i].md, vt[i].a, vt[i].b, vt[i].d);
      if (vt[i].d != 5'd0) sb_q.push_back({vt[i].d, vt[i].e_res});
      wait_start($sformatf("v%0d", i), ok);
      if (ok) begin
        check($sformatf("v%0d_num", i),  div_numerator,   vt[i].e_num);
        check($sformatf("v%0d_den", i),  div_denominator, vt[i].e_den);
        check($sformatf("v%0d_sign", i), {31'd0, div_sign}, {31'd0, vt[i].e_sign});
        check($sformatf("v%0d_mod", i),  {31'd0, div_mod},  {31'd0, vt[i].md});
        check($sformatf("v%0d_dest", i), {27'd0, div_latent_dest}, {27'd0, vt[i].d});
      end
      @(negedge clock);
      p3_div_op = 1'b0;
      wait_drain($sformatf("v%0d", i));
      check($sformatf("v%0d_wb_count", i), 32'(wb_count - wb0), (vt[i].d != 5'd0) ? 32'd1 : 32'd0);
    end

    // RAW hazard on r3
    @(negedge clock);
    drive_op(1'b0, 1'b0, 32'd50, 32'd5, 5'd3);
    sb_q.push_back({5'd3, 32'd10});
    p2_src_a = 5'd3; p2_use_a = 1'b1;
    #1;
    check("haz_issue_start", {31'd0, div_start}, 32'd1);
    check("haz_issue_stall", {31'd0, stall},     32'd1);
    @(negedge clock);
    p3_div_op = 1'b0; p2_src_a = 5'd4;
    #1;
    check("haz_r4_nostall", {31'd0, stall}, 32'd0);
    @(negedge clock);
    p2_use_a = 1'b0; p2_write = 1'b1; p2_dest = 5'd3;
    #1;
    check("haz_waw_stall", {31'd0, stall}, 32'd1);
    @(negedge clock);
    p2_write = 1'b0; p2_dest = 5'd0; p2_src_a = 5'd3; p2_use_a = 1'b1;
    low = 0; seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      #1;
      if (wbd_en) begin
        seen = 1'b1;
        check("haz_stall_at_wb", {31'd0, stall}, 32'd1);
      end else if (!stall) low++;
      @(negedge clock);
    end
    check("haz_wb_seen",    {31'd0, seen}, 32'd1);
    check("haz_stall_held", 32'(low),      32'd0);
    #1;
    check("haz_clear_after_wb", {31'd0, stall}, 32'd0);
    p2_use_a = 1'b0;

    // writeback collision with p4
    @(negedge clock);
    drive_op(1'b0, 1'b0, 32'd81, 32'd9, 5'd13);
    sb_q.push_back({5'd13, 32'd9});
    wait_start("col", ok);
    @(negedge clock);
    p3_div_op = 1'b0;
    for (int i = 0; i < 100 && !div_valid; i++) @(negedge clock);
    check("col_valid_seen", {31'd0, div_valid}, 32'd1);
    p4_wb_en = 1'b1;
    #1;
    check("col_no_wb",    {31'd0, wbd_en}, 32'd0);
    check("col_no_stall", {31'd0, stall},  32'd0);
    @(negedge clock);
    p4_wb_en = 1'b0;
    #1;
    check("col_hold_stall", {31'd0, stall},  32'd1);
    check("col_hold_wb",    {31'd0, wbd_en}, 32'd1);
    check("col_hold_reg",   {27'd0, wbd_reg}, 32'd13);
    check("col_hold_data",  wbd_data,         32'd9);
    @(negedge clock);
    #1;
    check("col_after_stall", {31'd0, stall},  32'd0);
    check("col_after_wb",    {31'd0, wbd_en}, 32'd0);

    // back-to-back: divide by zero, then a second op waiting while BUSY
    @(negedge clock);
    drive_op(1'b0, 1'b0, 32'd9, 32'd0, 5'd14);
    sb_q.push_back({5'd14, 32'hFFFF_FFFF});
    wait_start("b2b_first", ok);
    @(negedge clock);
    drive_op(1'b0, 1'b0, 32'd30, 32'd3, 5'd15);
    sb_q.push_back({5'd15, 32'd10});
    early = 0; low = 0; seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      #1;
      if (div_start) early++;
      if (!stall) low++;
      if (wbd_en) seen = 1'b1;
      @(negedge clock);
    end
    check("b2b_wb_seen",     {31'd0, seen}, 32'd1);
    check("b2b_no_early",    32'(early),    32'd0);
    check("b2b_stall_held",  32'(low),      32'd0);
    #1;
    check("b2b_issue_after_wb", {31'd0, div_start}, 32'd1);
    check("b2b_issue_nostall",  {31'd0, stall},     32'd0);
    check("b2b_issue_num",      div_numerator,      32'd30);
    @(negedge clock);
    p3_div_op = 1'b0;
    wait_drain("b2b");

    // reset mid-operation
    @(negedge clock);
    drive_op(1'b0, 1'b0, 32'd1000, 32'd3, 5'd16);
    sb_q.push_back({5'd16, 32'd333});
    wait_start("rstop", ok);
    @(negedge clock);
    p3_div_op = 1'b0; p2_src_a = 5'd16; p2_use_a = 1'b1;
    repeat (9) @(negedge clock);
    #1;
    check("rstop_pre_stall", {31'd0, stall}, 32'd1);
    @(negedge clock);
    reset = 1'b1;
    sb_q.delete();
    #1;
    check("rstop_stall", {31'd0, stall},  32'd0);
    check("rstop_wbd",   {31'd0, wbd_en}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rstop_pend_cleared", {31'd0, stall}, 32'd0);
    p2_use_a = 1'b0;
    wb0 = wb_count;
    repeat (50) @(negedge clock);
    check("rstop_no_wb", 32'(wb_count - wb0), 32'd0);
    drive_op(1'b0, 1'b0, 32'd20, 32'd4, 5'd17);
    sb_q.push_back({5'd17, 32'd5});
    wait_start("rstop_new", ok);
    @(negedge clock);
    p3_div_op = 1'b0;
    wait_drain("rstop_new");
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
